// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolver front end.
//   - default pixel width, maximum row length and buffered line count
//   - FSM state encoding for conv_line_buffer (IDLE / FILL / RUN)
//   - conv_addr_w(): column address width for a given maximum row length
package conv_pkg;

  localparam int CONV_DATA_W    = 16;
  localparam int CONV_MAX_ROW   = 256;
  localparam int CONV_NUM_LINES = 2;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // Column address width; at least one bit even for a degenerate row length.
  function automatic int conv_addr_w(input int max_row);
    return (max_row < 2) ? 1 : $clog2(max_row);
  endfunction

endpackage

// File: rtl/conv_line_buffer_if.sv
// conv_line_buffer_if: pixel-stream and column-output bundle of conv_line_buffer.
//   cfg_load/cfg_row_length : configuration strobe and row length (master -> slave)
//   in_valid/in_data        : raster pixel input (master -> slave)
//   col_valid/col_data/col_idx/primed : column output (slave -> master)
//
// Handshake: there is no back-pressure. A pixel is transferred in every cycle
// where in_valid is high (and cfg_load is low, and the block has been
// configured). col_valid is a single-cycle pulse; col_data/col_idx are only
// meaningful while col_valid is high and must be captured in that cycle.
interface conv_line_buffer_if
  import conv_pkg::*;
#(
  parameter int DATA_W    = CONV_DATA_W,
  parameter int MAX_ROW   = CONV_MAX_ROW,
  parameter int NUM_LINES = CONV_NUM_LINES
);
  localparam int ADDR_W = conv_addr_w(MAX_ROW);

  logic                            cfg_load;
  logic [ADDR_W:0]                 cfg_row_length;
  logic                            in_valid;
  logic [DATA_W-1:0]               in_data;
  logic                            col_valid;
  logic [(NUM_LINES+1)*DATA_W-1:0] col_data;
  logic [ADDR_W-1:0]               col_idx;
  logic                            primed;

  modport master (
    output cfg_load, cfg_row_length, in_valid, in_data,
    input  col_valid, col_data, col_idx, primed
  );

  modport slave (
    input  cfg_load, cfg_row_length, in_valid, in_data,
    output col_valid, col_data, col_idx, primed
  );

endinterface

// File: rtl/line_ram.sv
// line_ram: simple dual-port RAM holding one image row.
//   clk             : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i    : read request; data appears on rdata_o one cycle later
//   rdata_o         : registered read data (read-first: a same-cycle write to
//                     the read address is not visible)
// Contents are never reset.
module line_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: multi-line buffer producing, per input pixel, a vertical
// column of NUM_LINES+1 pixels (current row plus NUM_LINES rows above).
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : cfg_load/cfg_row_length, in_valid/in_data inputs;
//                  col_valid/col_data/col_idx/primed outputs (1-cycle latency)
//   dbg_state_o  : current FSM state (S_IDLE/S_FILL/S_RUN)
// Build option: define CONV_LINE_BUFFER_PAD_EN to emit a column for every
// pixel from the first row (unfilled taps read 0). Without it, columns are
// only emitted once NUM_LINES full rows are stored.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W    = CONV_DATA_W,
  parameter int MAX_ROW   = CONV_MAX_ROW,
  parameter int NUM_LINES = CONV_NUM_LINES
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_line_buffer_if.slave    bus,
  output state_t               dbg_state_o
);

  localparam int ADDR_W = conv_addr_w(MAX_ROW);
  localparam int LEN_W  = ADDR_W + 1;
  localparam int ROW_W  = $clog2(NUM_LINES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_ROW);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(NUM_LINES);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_LINES - 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;

  // Stage 1: the pixel accepted last cycle, its column and the number of
  // complete rows stored before it. Its cascade write happens now.
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_pix_q;
  logic [ROW_W-1:0]  s1_rows_q;
  logic              s1_fwd_q;
  logic [DATA_W-1:0] fwd_q [NUM_LINES];

  logic              col_valid_q;
  logic [ADDR_W-1:0] col_idx_q;

  logic [DATA_W-1:0] ram_q [NUM_LINES];
  logic [DATA_W-1:0] rd    [NUM_LINES];
  logic [DATA_W-1:0] wr    [NUM_LINES];

  logic accept, wrap, emit, fwd_hit;

  assign accept  = bus.in_valid && !bus.cfg_load && (state_q != S_IDLE);
  assign wrap    = ({1'b0, col_q} == (len_q - LEN_W'(1)));
  // The read of this cycle hits the address written this cycle; the RAM is
  // read-first, so the write data must be carried over explicitly.
  assign fwd_hit = accept && s1_valid_q && (col_q == s1_addr_q);

`ifdef CONV_LINE_BUFFER_PAD_EN
  assign emit = accept;
`else
  assign emit = accept && (state_q == S_RUN);
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    col_d   = col_q;
    row_d   = row_q;
    if (bus.cfg_load) begin
      state_d = S_FILL;
      col_d   = '0;
      row_d   = '0;
      if (bus.cfg_row_length == '0)          len_d = LEN_W'(1);
      else if (bus.cfg_row_length > MAX_LEN) len_d = MAX_LEN;
      else                                   len_d = bus.cfg_row_length;
    end else if (accept) begin
      if (wrap) begin
        col_d = '0;
        if (row_q != ROW_FULL) row_d = row_q + ROW_W'(1);
        if (state_q == S_FILL && row_q == ROW_LAST) state_d = S_RUN;
      end else begin
        col_d = col_q + ADDR_W'(1);
      end
    end
  end

  // Cascade: RAM0 takes the stage-1 pixel, RAM k takes what RAM k-1 held.
  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    assign rd[k] = s1_fwd_q ? fwd_q[k] : ram_q[k];
    if (k == 0) begin : g_head
      assign wr[k] = s1_pix_q;
    end else begin : g_tail
      assign wr[k] = rd[k-1];
    end
    line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_ROW), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we_i    (s1_valid_q),
      .waddr_i (s1_addr_q),
      .wdata_i (wr[k]),
      .re_i    (accept),
      .raddr_i (col_q),
      .rdata_o (ram_q[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= LEN_W'(1);
      col_q       <= '0;
      row_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_pix_q    <= '0;
      s1_rows_q   <= '0;
      s1_fwd_q    <= 1'b0;
      col_valid_q <= 1'b0;
      col_idx_q   <= '0;
      for (int k = 0; k < NUM_LINES; k++) fwd_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s1_valid_q  <= accept;
      s1_fwd_q    <= fwd_hit;
      col_valid_q <= emit;
      if (accept) begin
        s1_addr_q <= col_q;
        s1_pix_q  <= bus.in_data;
        s1_rows_q <= row_q;
        col_idx_q <= col_q;
      end
      if (fwd_hit) begin
        for (int k = 0; k < NUM_LINES; k++) fwd_q[k] <= wr[k];
      end
    end
  end

  // Taps above the stored row count are masked; all taps read 0 outside
  // a valid pulse.
  always_comb begin
    bus.col_data = '0;
    if (col_valid_q) begin
      bus.col_data[0 +: DATA_W] = s1_pix_q;
      for (int k = 1; k <= NUM_LINES; k++) begin
        if (s1_rows_q >= ROW_W'(k)) bus.col_data[k*DATA_W +: DATA_W] = rd[k-1];
      end
    end
  end

  assign bus.col_valid = col_valid_q;
  assign bus.col_idx   = col_idx_q;
  assign bus.primed    = (state_q == S_RUN);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_conv_line_buffer.sv
// tb_conv_line_buffer: randomized and directed stimulus for conv_line_buffer,
// checked by a scoreboard fed from a frame-level reference model (each tap k
// is the pixel k*len positions earlier in the frame, or 0 if none exists).
module tb_conv_line_buffer;
  import conv_pkg::*;

  localparam int DATA_W    = 16;
  localparam int MAX_ROW   = 256;
  localparam int NUM_LINES = 2;
  localparam int ADDR_W    = $clog2(MAX_ROW);
  localparam int LEN_W     = ADDR_W + 1;
  localparam int TW        = (NUM_LINES + 1) * DATA_W;
  localparam int EW        = ADDR_W + TW;

`ifdef CONV_LINE_BUFFER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  always #5 clk = ~clk;

  conv_line_buffer_if #(.DATA_W(DATA_W), .MAX_ROW(MAX_ROW), .NUM_LINES(NUM_LINES)) bus_if ();

  conv_line_buffer #(.DATA_W(DATA_W), .MAX_ROW(MAX_ROW), .NUM_LINES(NUM_LINES)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int                total = 0;
  int                bad   = 0;
  int                n_pulses = 0;
  logic [EW-1:0]     exp_q[$];
  bit                m_active;
  int                m_len;
  logic [DATA_W-1:0] m_px[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_primed();
    return m_active && (m_px.size() >= NUM_LINES * m_len);
  endfunction

  // Frame-level model: called once per clock edge with what was presented.
  task automatic model_update(input logic cfg, input logic [LEN_W-1:0] len,
                              input logic v, input logic [DATA_W-1:0] d);
    int            n;
    bit            emit;
    logic [TW-1:0] taps;
    if (cfg) begin
      m_active = 1'b1;
      if (len == 0)             m_len = 1;
      else if (int'(len) > MAX_ROW) m_len = MAX_ROW;
      else                      m_len = int'(len);
      m_px.delete();
    end else if (v && m_active) begin
      n = m_px.size();
      m_px.push_back(d);
      emit = PAD || (n >= NUM_LINES * m_len);
      if (emit) begin
        taps = '0;
        for (int k = 0; k <= NUM_LINES; k++) begin
          if (n - k * m_len >= 0) taps[k*DATA_W +: DATA_W] = m_px[n - k*m_len];
        end
        exp_q.push_back({ADDR_W'(n % m_len), taps});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic cfg, input int len, input logic v, input logic [DATA_W-1:0] d);
    bus_if.cfg_load       = cfg;
    bus_if.cfg_row_length = LEN_W'(len);
    bus_if.in_valid       = v;
    bus_if.in_data        = d;
    @(posedge clk);
    model_update(cfg, LEN_W'(len), v, d);
    #1;
    bus_if.cfg_load = 1'b0;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, '0);
  endtask

  task automatic stream_random(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      step(1'b0, 0, 1'b1, DATA_W'($urandom));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_col_valid"}, EW'(bus_if.col_valid), EW'(0));
    check({tag, "_col_data"},  EW'(bus_if.col_data),  EW'(0));
    check({tag, "_col_idx"},   EW'(bus_if.col_idx),   EW'(0));
    check({tag, "_primed"},    EW'(bus_if.primed),    EW'(0));
    check({tag, "_state"},     EW'(dbg_state),        EW'(S_IDLE));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("primed", EW'(bus_if.primed), EW'(model_primed()));
      if (bus_if.col_valid === 1'b1) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL col_unexpected: got idx=%0h data=%0h expected no pulse",
                   bus_if.col_idx, bus_if.col_data);
        end else begin
          check("col", {bus_if.col_idx, bus_if.col_data}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int base;
  int rows;
  int len;

  initial begin
    rst = 1'b1;
    bus_if.cfg_load = 1'b0;
    bus_if.cfg_row_length = '0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data = '0;
    m_active = 1'b0;
    m_len = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pixels before any cfg_load are ignored.
    base = n_pulses;
    stream_random(4, 1'b0);
    idle(2);
    check("idle_no_pulse", EW'(n_pulses - base), EW'(0));
    check("idle_state", EW'(dbg_state), EW'(S_IDLE));

    // len=4, pixels 1..16.
    step(1'b1, 4, 1'b0, '0);
    check("fill_state", EW'(dbg_state), EW'(S_FILL));
    base = n_pulses;
    for (int v = 1; v <= 16; v++) step(1'b0, 0, 1'b1, DATA_W'(v));
    idle(2);
    check("len4_pulses", EW'(n_pulses - base), EW'(PAD ? 16 : 8));
    check("len4_state", EW'(dbg_state), EW'(S_RUN));

    // len=1, back-to-back repeated address 0.
    step(1'b1, 1, 1'b0, '0);
    for (int v = 7; v <= 10; v++) step(1'b0, 0, 1'b1, DATA_W'(v));
    idle(2);

    // len=0 latches as 1, with gaps.
    step(1'b1, 0, 1'b0, '0);
    stream_random(8, 1'b1);
    idle(2);

    // Full-width rows with random gaps: exercises col_idx wrap 255 -> 0.
    step(1'b1, MAX_ROW, 1'b0, '0);
    stream_random(4 * MAX_ROW, 1'b1);
    idle(2);
    check("maxrow_state", EW'(dbg_state), EW'(S_RUN));

    // Over-range length latches as MAX_ROW.
    step(1'b1, 300, 1'b0, '0);
    stream_random(2 * MAX_ROW + 10, 1'b0);
    idle(2);

    // cfg_load together with in_valid mid-row: pixel dropped, fill restarts.
    step(1'b1, 5, 1'b0, '0);
    stream_random(12, 1'b0);
    step(1'b1, 5, 1'b1, 16'hDEAD);
    check("midrow_state", EW'(dbg_state), EW'(S_FILL));
    stream_random(13, 1'b0);
    idle(2);

    // Random short frames.
    for (int f = 0; f < 8; f++) begin
      len  = $urandom_range(1, 12);
      rows = $urandom_range(2, 4);
      step(1'b1, len, 1'b0, '0);
      stream_random(rows * len + $urandom_range(0, len - 1), 1'b1);
    end
    idle(2);

    // Reset during RUN.
    step(1'b1, 3, 1'b0, '0);
    stream_random(9, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    m_active = 1'b0;
    m_px.delete();
    @(negedge clk);
    check_outputs_zero("rst_run");
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = n_pulses;
    stream_random(6, 1'b0);
    idle(2);
    check("post_rst_no_pulse", EW'(n_pulses - base), EW'(0));
    check("post_rst_state", EW'(dbg_state), EW'(S_IDLE));

    idle(2);
    check("drain", EW'(exp_q.size()), EW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_line_buffer.md
# conv_line_buffer

Parametrised multi-line buffer for the convolver front end. It takes a raster pixel stream and, for each input pixel, presents a vertical column of NUM_LINES+1 pixels: the current pixel and the pixels at the same column in the NUM_LINES previous rows. It feeds the convolver window registers. Row length is set at run time, and row lengths from 1 to MAX_ROW are handled exactly, with no alignment offset.

## Interface
- DATA_W, 16, pixel width in bits
- MAX_ROW, 256, maximum row length in pixels (≥2)
- NUM_LINES, 2, rows held in buffer (kernel height − 1, ≥1)
- ADDR_W, $clog2(MAX_ROW), column address width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_load  in  1  one-cycle strobe: latch cfg_row_length, restart the frame
- cfg_row_length  in  ADDR_W+1  pixels per row (1..MAX_ROW)
- in_valid  in  1  in_data valid this cycle
- in_data  in  DATA_W  input pixel, raster order
- col_valid  out  1  col_data/col_idx valid (single-cycle pulse per pixel)
- col_data  out  (NUM_LINES+1)*DATA_W  tap k at bits [k*DATA_W +: DATA_W]; tap 0 = current row, tap k = k rows above
- col_idx  out  ADDR_W  column of the current output
- primed  out  1  NUM_LINES full rows have been stored since the last cfg_load

## Operation
- State machine: IDLE → (cfg_load) FILL → (row counter reaches NUM_LINES at end of row) RUN. cfg_load from any state goes to FILL with counters cleared. in_valid in IDLE is ignored.
- Row-length latch: 0 is latched as 1; values > MAX_ROW are latched as MAX_ROW.
- Column counter: increments on each accepted pixel and wraps to 0 after len−1. At wrap, the row counter increments, saturating at NUM_LINES.
- Storage: NUM_LINES line RAMs, each MAX_ROW×DATA_W, cascaded. RAM0 holds the previous row and RAM k the row k+1 above. For a pixel at column c: RAM0[c] ← in_data, RAM k[c] ← old RAM(k−1)[c].
- Unfilled rows: when fewer than k rows are stored, the tap k output is masked to 0. RAM contents are never reset.
- cfg_load with in_valid in the same cycle: cfg_load wins and the pixel is dropped.
- Back-to-back accesses to the same address (len = 1, or wrap): a write pending from the previous cycle to the address being read is forwarded. Taps must always equal the true previous rows.

## Timing
- Latency: col_valid/col_data/col_idx are registered and appear 1 cycle after the accepted in_valid.
- Throughput: 1 pixel/cycle sustained, with no stalls. in_valid gaps of any length are allowed.
- Pipeline: the RAM read is issued in the cycle the pixel is accepted. The cascade write happens in the following cycle, at the same address as the read.
- Reset values: col_valid=0, col_data=0, col_idx=0, primed=0, state=IDLE, latched length=1.
- rst mid-frame: the block returns to IDLE immediately. Any in-flight output is discarded, and a cfg_load is required before new data is accepted.
- primed: rises in the cycle after the last pixel of row NUM_LINES−1 is accepted. It falls in the cycle after cfg_load.

## Configuration
- CONV_LINE_BUFFER_PAD_EN defined: col_valid pulses for every accepted pixel from the first row. Taps for unfilled rows read 0, giving top zero-padding.
- Not defined: col_valid pulses only for pixels accepted while primed=1, i.e. from row NUM_LINES onward. Earlier pixels are still stored.

## Structure
- Shared package conv_pkg holds the state encoding (IDLE/FILL/RUN), DATA_W/MAX_ROW defaults, and the ADDR_W derivation.
- Sub-module line_ram: simple dual-port RAM with read-first behaviour, registered read, 1-cycle read latency, and one write port. It is instantiated NUM_LINES times. Forwarding logic stays in conv_line_buffer.

## Test plan
- Reset then cfg_load len=4, stream values 1..16, PAD_EN off → the first col_valid is for pixel 9. Output is taps {9,5,1}, then {10,6,2} … {16,12,8}, and col_idx cycles 0..3.
- Same stream with PAD_EN on → 16 pulses. Pixel 1 gives {1,0,0}, pixel 5 gives {5,1,0}, pixel 9 gives {9,5,1}.
- len=1, stream 7,8,9,10 back-to-back → pixel 10 gives {10,9,8}. This checks forwarding on repeated address 0.
- len=MAX_ROW with random in_valid gaps → every tap k equals the pixel MAX_ROW·k earlier, and col_idx wraps 255→0.
- cfg_load asserted together with in_valid mid-row → that pixel is absent from the outputs, primed drops, and fill restarts from col 0.
- Assert rst during RUN → all outputs are 0 on the next edge. A subsequent stream without cfg_load gives no col_valid.
